regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write_enable / write_index / write_data) between NUM_REQ writeback sources (ALU, load unit, immediate/move path).
- Round-robin arbitration with a valid/ready handshake; drives a registered write port.
- Applies 16-bit truncation for indices 0..LONG_BASE-1 and passes the full 24 bits for the long registers LONG_BASE..31.
- Keeps a 32-bit pending-write scoreboard, reserved at issue and cleared at writeback, which decode uses for hazard stalls.

Parameters:
- NUM_REQ, 3, number of writeback requesters; requester 0 = ALU, 1 = load, 2 = imm.
- DATA_W, 24, write data width (widest register).
- IDX_W, 5, register index width (32 registers).
- SHORT_W, 16, width of the short registers.
- LONG_BASE, 28, first index of the 24-bit registers (28..31).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; combinational, one-hot or zero.
- req_index  in  NUM_REQ*IDX_W  packed target indices; requester i occupies bits [i*IDX_W +: IDX_W].
- req_data  in  NUM_REQ*DATA_W  packed write data; same packing.
- reserve_valid  in  1  decode reserves a destination register.
- reserve_index  in  IDX_W  index being reserved.
- write_enable  out  1  registered register-file write strobe.
- write_index  out  IDX_W  registered write index.
- write_data  out  DATA_W  registered, width-masked write data.
- pend_mask  out  32  registered scoreboard; bit k=1 means a write to register k is outstanding.
- grant_id  out  2  registered id of the requester that drove the current write (debug/perf).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - write_enable=0, write_index=0, write_data=0, grant_id=0, pend_mask=0, rr_ptr=0.
  - req_ready is forced to 0 while rst_n=0.
  - Reset mid-handshake discards the request; the requester must re-present it.
- Handshake:
  - A transfer occurs on a cycle where req_valid[i]=1 and req_ready[i]=1.
  - A requester holds valid, index and data stable until it sees ready; dropping valid before ready is legal and means no transfer.
  - req_ready does not depend on the requester's own ready history. Loops are limited to valid→ready.
- Arbitration:
  - Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NUM_REQ. The first valid requester is granted.
  - Exactly one grant per cycle whenever any valid is high; the port never stalls.
  - After granting i: rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - Any continuously valid requester is therefore granted within NUM_REQ cycles.
- Write stage (latency 1):
  - A grant in cycle N gives write_enable=1 in cycle N+1, with write_index=req_index[i] and grant_id=i.
  - If req_index[i] < LONG_BASE: write_data = {zeros, req_data[i][SHORT_W-1:0]}. Otherwise write_data = req_data[i] in full.
  - With no grant in cycle N: write_enable=0 in N+1; write_index and write_data hold their previous values.
- Scoreboard:
  - On the edge ending a cycle with reserve_valid=1, pend_mask[reserve_index] <= 1.
  - On the edge ending a granted cycle, pend_mask[granted index] <= 0. Because of this, pend_mask is clear in the same cycle write_enable is high.
  - Set and clear of the same index on the same edge: set wins, since it is a newer reservation.
  - Set and clear of different indices on the same edge: both apply.
  - A write to an index that is not pending is legal; the bit stays 0.
  - Reserving an already-set bit is legal; the bit stays 1. There is no counting, so decode stalls on a set bit before re-reserving.
- Same-index writes from two requesters in consecutive cycles are both issued in grant order; the last one wins in the register file.

Test Plan:
- Reset, then single request: hold rst_n=0 for 2 cycles with req_valid=3'b111. Expect req_ready=0 and all outputs 0 throughout. Release reset; ALU (req 0) writes index 5, data 24'hABCDEF. Expect req_ready=3'b001 the same cycle; next cycle write_enable=1, write_index=5, write_data=24'h00CDEF, grant_id=0.
- Long register: load (req 1) writes index 30, data 24'h123456. Expect write_data=24'h123456 and write_index=30 one cycle later.
- Round-robin: all three valid for 6 cycles from reset. Expect grants 0,1,2,0,1,2. Then hold only req 2 valid: granted every cycle, with write_enable high on each following cycle.
- Fairness after idle: grant req 1 once, then go idle 3 cycles (rr_ptr=2), then assert 0 and 2 together. Expect req 2 granted first, then req 0.
- Scoreboard: reserve index 7, then index 29 on consecutive cycles. Expect pend_mask bits 7 and 29 set. Write index 7 via req 0: expect bit 7 clear in the same cycle write_enable=1, bit 29 still set.
- Set/clear collision: with pend_mask[9]=1, in one cycle grant a write to index 9 and assert reserve_index=9. Expect pend_mask[9]=1 afterwards. Then assert rst_n=0 with a request pending: expect pend_mask=0, write_enable=0, and no grant.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the shared register-file write port.
// It drives a registered, width-masked write port and keeps the pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int DATA_W    = 24,
  parameter int IDX_W     = 5,
  parameter int SHORT_W   = 16,
  parameter int LONG_BASE = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]   req_index,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       reserve_valid,
  input  logic [IDX_W-1:0]           reserve_index,
  output logic                       write_enable,
  output logic [IDX_W-1:0]           write_index,
  output logic [DATA_W-1:0]          write_data,
  output logic [31:0]                pend_mask,
  output logic [1:0]                 grant_id
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              write_enable_q, write_enable_d;
  logic [IDX_W-1:0]  write_index_q, write_index_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [31:0]       pend_q, pend_d;
  logic [1:0]        grant_id_q, grant_id_d;

  logic              gnt_any_s;
  logic [PTR_W-1:0]  gnt_idx_s;
  logic [PTR_W:0]    sum_s;
  logic [PTR_W-1:0]  cand_s;
  logic              hit_s;
  logic [IDX_W-1:0]  sel_index_s;
  logic [DATA_W-1:0] sel_data_s;

  // Rotating priority search starting at rr_ptr; nothing is granted while in reset.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    sum_s     = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s     = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      cand_s    = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum_s - (PTR_W+1)'(NUM_REQ))
                                                 : sum_s[PTR_W-1:0];
      hit_s     = rst_n && !gnt_any_s && req_valid[cand_s];
      gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
      gnt_any_s = gnt_any_s | hit_s;
    end
  end

  // One-hot ready for the granted requester.
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = gnt_any_s && (gnt_idx_s == PTR_W'(k));
    end
  end

  assign sel_index_s = req_index[int'(gnt_idx_s)*IDX_W +: IDX_W];
  assign sel_data_s  = req_data[int'(gnt_idx_s)*DATA_W +: DATA_W];

  // Next state of the write stage, pointer and scoreboard.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    write_enable_d = 1'b0;
    write_index_d  = write_index_q;
    write_data_d   = write_data_q;
    grant_id_d     = grant_id_q;
    pend_d         = pend_q;
    if (gnt_any_s) begin
      rr_ptr_d       = (gnt_idx_s == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx_s + PTR_W'(1);
      write_enable_d = 1'b1;
      write_index_d  = sel_index_s;
      write_data_d   = (sel_index_s < IDX_W'(LONG_BASE)) ? DATA_W'(sel_data_s[SHORT_W-1:0])
                                                         : sel_data_s;
      grant_id_d     = 2'(gnt_idx_s);
      pend_d[sel_index_s] = 1'b0;
    end else begin
      write_enable_d = 1'b0;
    end
    // Applied after the clear so a fresh reservation of the written index survives.
    if (reserve_valid) begin
      pend_d[reserve_index] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      write_enable_q <= 1'b0;
      write_index_q  <= '0;
      write_data_q   <= '0;
      grant_id_q     <= 2'd0;
      pend_q         <= 32'd0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      write_enable_q <= write_enable_d;
      write_index_q  <= write_index_d;
      write_data_q   <= write_data_d;
      grant_id_q     <= grant_id_d;
      pend_q         <= pend_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_index  = write_index_q;
  assign write_data   = write_data_q;
  assign pend_mask    = pend_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, random traffic against a
// reference model of the arbitration/scoreboard rules, and a fairness bound check.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_index;
  logic [71:0] req_data;
  logic        reserve_valid;
  logic [4:0]  reserve_index;
  logic        write_enable;
  logic [4:0]  write_index;
  logic [23:0] write_data;
  logic [31:0] pend_mask;
  logic [1:0]  grant_id;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_data(req_data), .reserve_valid(reserve_valid),
    .reserve_index(reserve_index), .write_enable(write_enable), .write_index(write_index),
    .write_data(write_data), .pend_mask(pend_mask), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [4:0]  i0, i1, i2;
    logic [23:0] d0, d1, d2;
    logic        rv;
    logic [4:0]  ri;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_widx;
    logic [23:0] e_wdata;
    logic [1:0]  e_gid;
    logic [31:0] e_pend;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [2:0] last_ready = 3'b000;

  // Reference model state
  int          m_ptr = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_widx = 5'd0;
  logic [23:0] m_wdata = 24'd0;
  logic [1:0]  m_gid = 2'd0;
  logic [31:0] m_pend = 32'd0;

  function automatic vec_t mk(input logic rst, input logic [2:0] valid,
                              input logic [4:0] i0, input logic [23:0] d0,
                              input logic [4:0] i1, input logic [23:0] d1,
                              input logic [4:0] i2, input logic [23:0] d2,
                              input logic rv, input logic [4:0] ri,
                              input logic [2:0] er, input logic ewe, input logic [4:0] ewi,
                              input logic [23:0] ewd, input logic [1:0] egid, input logic [31:0] epend);
    vec_t v;
    v.rst = rst; v.valid = valid; v.i0 = i0; v.i1 = i1; v.i2 = i2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.rv = rv; v.ri = ri;
    v.e_ready = er; v.e_we = ewe; v.e_widx = ewi; v.e_wdata = ewd; v.e_gid = egid; v.e_pend = epend;
    return v;
  endfunction

  // Winner = valid requester with the smallest circular distance from the pointer.
  function automatic int model_grant(input logic [2:0] valid);
    int best = -1;
    int bestd = 99;
    for (int i = 0; i < 3; i++) begin
      int d = (i - m_ptr + 3) % 3;
      if (valid[i] && d < bestd) begin
        best = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_update(input vec_t v, input int g);
    logic [4:0]  idx[3];
    logic [23:0] dat[3];
    idx[0] = v.i0; idx[1] = v.i1; idx[2] = v.i2;
    dat[0] = v.d0; dat[1] = v.d1; dat[2] = v.d2;
    if (!v.rst) begin
      m_ptr = 0; m_we = 1'b0; m_widx = 5'd0; m_wdata = 24'd0; m_gid = 2'd0; m_pend = 32'd0;
    end else begin
      if (g >= 0) begin
        m_we    = 1'b1;
        m_widx  = idx[g];
        m_wdata = (idx[g] < 5'd28) ? {8'h00, dat[g][15:0]} : dat[g];
        m_gid   = 2'(g);
        m_ptr   = (g + 1) % 3;
        m_pend[idx[g]] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (v.rv) m_pend[v.ri] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, check comb ready before the edge and registered outputs after it.
  task automatic run_cycle(input vec_t v, input bit use_tab);
    logic [2:0] exp_r;
    int g;
    rst_n = v.rst; req_valid = v.valid;
    req_index = {v.i2, v.i1, v.i0}; req_data = {v.d2, v.d1, v.d0};
    reserve_valid = v.rv; reserve_index = v.ri;
    #1;
    g = model_grant(v.valid);
    exp_r = (v.rst && g >= 0) ? 3'(1 << g) : 3'b000;
    last_ready = req_ready;
    chk("req_ready", {29'd0, req_ready}, {29'd0, use_tab ? v.e_ready : exp_r});
    @(posedge clk);
    model_update(v, g);
    #1;
    chk("write_enable", {31'd0, write_enable}, {31'd0, use_tab ? v.e_we : m_we});
    chk("write_index", {27'd0, write_index}, {27'd0, use_tab ? v.e_widx : m_widx});
    chk("write_data", {8'd0, write_data}, {8'd0, use_tab ? v.e_wdata : m_wdata});
    chk("grant_id", {30'd0, grant_id}, {30'd0, use_tab ? v.e_gid : m_gid});
    chk("pend_mask", pend_mask, use_tab ? v.e_pend : m_pend);
    @(negedge clk);
  endtask

  vec_t tab[$];
  vec_t rv_v;
  logic [2:0]  cur_valid;
  logic [4:0]  cur_idx[3];
  logic [23:0] cur_dat[3];
  int waited;

  initial begin
    rst_n = 1'b0; req_valid = 3'b000; req_index = 15'd0; req_data = 72'd0;
    reserve_valid = 1'b0; reserve_index = 5'd0;

    // Reset with all valid, then single ALU write and long-register load write
    for (int r = 0; r < 2; r++)
      tab.push_back(mk(1'b0, 3'b111, 5'd5, 24'hABCDEF, 5'd30, 24'h123456, 5'd7, 24'h777777,
                       1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 24'h0, 2'd0, 32'h0));
    tab.push_back(mk(1'b1, 3'b001, 5'd5, 24'hABCDEF, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b0, 5'd0, 3'b001, 1'b1, 5'd5, 24'h00CDEF, 2'd0, 32'h0));
    tab.push_back(mk(1'b1, 3'b010, 5'd0, 24'h0, 5'd30, 24'h123456, 5'd0, 24'h0,
                     1'b0, 5'd0, 3'b010, 1'b1, 5'd30, 24'h123456, 2'd1, 32'h0));
    tab.push_back(mk(1'b1, 3'b000, 5'd0, 24'h0, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b0, 5'd0, 3'b000, 1'b0, 5'd30, 24'h123456, 2'd1, 32'h0));
    // Round robin from reset
    tab.push_back(mk(1'b0, 3'b000, 5'd0, 24'h0, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 24'h0, 2'd0, 32'h0));
    for (int r = 0; r < 6; r++)
      tab.push_back(mk(1'b1, 3'b111, 5'd1, 24'h111111, 5'd2, 24'h222222, 5'd3, 24'h333333,
                       1'b0, 5'd0, 3'(1 << (r % 3)), 1'b1, 5'((r % 3) + 1),
                       24'(32'h1111 * ((r % 3) + 1)), 2'(r % 3), 32'h0));
    for (int r = 0; r < 3; r++)
      tab.push_back(mk(1'b1, 3'b100, 5'd0, 24'h0, 5'd0, 24'h0, 5'd29, 24'hABCDEF,
                       1'b0, 5'd0, 3'b100, 1'b1, 5'd29, 24'hABCDEF, 2'd2, 32'h0));
    // Fairness after idle
    tab.push_back(mk(1'b1, 3'b010, 5'd0, 24'h0, 5'd4, 24'h77BEEF, 5'd0, 24'h0,
                     1'b0, 5'd0, 3'b010, 1'b1, 5'd4, 24'h00BEEF, 2'd1, 32'h0));
    for (int r = 0; r < 3; r++)
      tab.push_back(mk(1'b1, 3'b000, 5'd0, 24'h0, 5'd0, 24'h0, 5'd0, 24'h0,
                       1'b0, 5'd0, 3'b000, 1'b0, 5'd4, 24'h00BEEF, 2'd1, 32'h0));
    tab.push_back(mk(1'b1, 3'b101, 5'd10, 24'h0A0A0A, 5'd0, 24'h0, 5'd31, 24'hF0F0F0,
                     1'b0, 5'd0, 3'b100, 1'b1, 5'd31, 24'hF0F0F0, 2'd2, 32'h0));
    tab.push_back(mk(1'b1, 3'b001, 5'd10, 24'h0A0A0A, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b0, 5'd0, 3'b001, 1'b1, 5'd10, 24'h000A0A, 2'd0, 32'h0));
    // Scoreboard reserve and clear
    tab.push_back(mk(1'b1, 3'b000, 5'd0, 24'h0, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b1, 5'd7, 3'b000, 1'b0, 5'd10, 24'h000A0A, 2'd0, 32'h0000_0080));
    tab.push_back(mk(1'b1, 3'b000, 5'd0, 24'h0, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b1, 5'd29, 3'b000, 1'b0, 5'd10, 24'h000A0A, 2'd0, 32'h2000_0080));
    tab.push_back(mk(1'b1, 3'b001, 5'd7, 24'h777777, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b0, 5'd0, 3'b001, 1'b1, 5'd7, 24'h007777, 2'd0, 32'h2000_0000));
    // Set/clear collision, different-index set+clear, write to non-pending index
    tab.push_back(mk(1'b1, 3'b000, 5'd0, 24'h0, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b1, 5'd9, 3'b000, 1'b0, 5'd7, 24'h007777, 2'd0, 32'h2000_0200));
    tab.push_back(mk(1'b1, 3'b010, 5'd0, 24'h0, 5'd9, 24'h999999, 5'd0, 24'h0,
                     1'b1, 5'd9, 3'b010, 1'b1, 5'd9, 24'h009999, 2'd1, 32'h2000_0200));
    tab.push_back(mk(1'b1, 3'b100, 5'd0, 24'h0, 5'd0, 24'h0, 5'd29, 24'h5A5A5A,
                     1'b1, 5'd3, 3'b100, 1'b1, 5'd29, 24'h5A5A5A, 2'd2, 32'h0000_0208));
    tab.push_back(mk(1'b1, 3'b001, 5'd12, 24'h0000FF, 5'd0, 24'h0, 5'd0, 24'h0,
                     1'b0, 5'd0, 3'b001, 1'b1, 5'd12, 24'h0000FF, 2'd0, 32'h0000_0208));
    // Reset with requests and a reservation pending
    tab.push_back(mk(1'b0, 3'b111, 5'd12, 24'h0000FF, 5'd1, 24'h1, 5'd2, 24'h2,
                     1'b1, 5'd5, 3'b000, 1'b0, 5'd0, 24'h0, 2'd0, 32'h0));

    foreach (tab[n]) run_cycle(tab[n], 1'b1);

    // Random traffic; pending requests are held until granted (occasionally withdrawn)
    cur_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cur_idx[i] = 5'd0;
      cur_dat[i] = 24'd0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(cur_valid[i] && !last_ready[i] && $urandom_range(0, 7) != 0)) begin
          cur_valid[i] = 1'($urandom_range(0, 1));
          cur_idx[i]   = 5'($urandom_range(0, 31));
          cur_dat[i]   = 24'($urandom);
        end
      end
      rv_v = mk(($urandom_range(0, 39) != 0), cur_valid, cur_idx[0], cur_dat[0],
                cur_idx[1], cur_dat[1], cur_idx[2], cur_dat[2],
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                3'b000, 1'b0, 5'd0, 24'd0, 2'd0, 32'd0);
      run_cycle(rv_v, 1'b0);
    end

    // A continuously valid requester must be granted within three cycles
    for (int t = 0; t < 6; t++) begin
      waited = 0;
      cur_idx[0] = 5'($urandom_range(0, 31));
      cur_dat[0] = 24'($urandom);
      do begin
        rv_v = mk(1'b1, {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1},
                  cur_idx[0], cur_dat[0], 5'($urandom_range(0, 31)), 24'($urandom),
                  5'($urandom_range(0, 31)), 24'($urandom), 1'b0, 5'd0,
                  3'b000, 1'b0, 5'd0, 24'd0, 2'd0, 32'd0);
        run_cycle(rv_v, 1'b0);
        waited++;
      end while (!last_ready[0] && waited < 8);
      chk("starve_bound", {31'd0, (waited <= 3)}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
